m_reqgen: RTL and testbench

Request generator and response checker for packet-interface bring-up. Issues a programmable series of alternating WRITE/READ request packets on its output stream, consumes the matching WRACK/RDATA responses on its input stream, and checks header, beat count and framing. Sits directly upstream of a slave-side responder and replaces it as the requester in unit benches and on-chip traffic tests.

---
 rtl/m_reqgen_pkg.sv | 56 +++++
 rtl/m_resp_check.sv | 71 +++++++
 rtl/m_reqgen.sv | 232 +++++++++++++++++++++++
 tb/tb_m_reqgen.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/m_reqgen_pkg.sv
// m_reqgen_pkg: shared packet constants, header layout and FSM states
// for the m_reqgen request generator and its response checker.
package m_reqgen_pkg;

   localparam logic [1:0] PT_READ  = 2'b00;
   localparam logic [1:0] PT_WRITE = 2'b01;
   localparam logic [1:0] PT_RDATA = 2'b10;
   localparam logic [1:0] PT_WRACK = 2'b11;

   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_HDR   = 2'd1;
   localparam logic [1:0] ERR_FRAME = 2'd2;
   localparam logic [1:0] ERR_TMO   = 2'd3;

   localparam int HDR_STRB_LSB = 56;
   localparam int HDR_SRC_LSB  = 48;
   localparam int HDR_LEN_LSB  = 40;
   localparam int HDR_TYPE_LSB = 32;
   localparam int HDR_ADDR_LSB = 3;

   localparam logic [63:0] DATA_TAG = 64'hda7a_0000_0000_0000;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ_HDR,
      S_REQ_DATA,
      S_RESP_HDR,
      S_RESP_DATA,
      S_DRAIN,
      S_DONE
   } state_e;

   function automatic logic [63:0] mk_hdr(
      input logic [7:0]  src,
      input logic [7:0]  len,
      input logic [1:0]  typ,
      input logic [28:0] addr
   );
      logic [63:0] h;
      h = '0;
      h[HDR_STRB_LSB +: 8]  = (typ == PT_WRITE) ? 8'hff : 8'h00;
      h[HDR_SRC_LSB  +: 8]  = src;
      h[HDR_LEN_LSB  +: 8]  = len;
      h[HDR_TYPE_LSB +: 2]  = typ;
      h[HDR_ADDR_LSB +: 29] = addr;
      return h;
   endfunction

   function automatic logic [63:0] mk_data(
      input logic [15:0] k,
      input logic [7:0]  i
   );
      return DATA_TAG | {40'd0, k, i};
   endfunction

endpackage

// File: rtl/m_resp_check.sv
// m_resp_check: per-beat header and framing check of one response packet.
// Ports: beat_i/hdr_i/data_i/last_i accepted beat; exp_* expectation; err_o/code_o/end_o verdict.
module m_resp_check
   import m_reqgen_pkg::*;
#(
   parameter logic [7:0] SRC_ID = 8'h01
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        beat_i,
   input  logic        hdr_i,
   input  logic        exp_rd_i,
   input  logic [28:0] exp_addr_i,
   input  logic [7:0]  exp_len_i,
   input  logic [63:0] data_i,
   input  logic        last_i,
   output logic        err_o,
   output logic [1:0]  code_o,
   output logic        end_o
);

   logic [7:0] cnt_q, cnt_d;
   logic [1:0] exp_type;
   logic       hdr_bad;
   logic       unused_hdr;

   assign unused_hdr = ^{data_i[63:56], data_i[47:34], data_i[2:0]};

   always_comb begin
      exp_type = exp_rd_i ? PT_RDATA : PT_WRACK;
      hdr_bad  = (data_i[HDR_TYPE_LSB +: 2] != exp_type)
              || (data_i[HDR_SRC_LSB +: 8] != SRC_ID)
              || (data_i[HDR_ADDR_LSB +: 29] != exp_addr_i);
      err_o  = 1'b0;
      code_o = ERR_NONE;
      end_o  = 1'b0;
      cnt_d  = cnt_q;
      if (beat_i) begin
         if (hdr_i) begin
            cnt_d = '0;
            if (hdr_bad) begin
               err_o  = 1'b1;
               code_o = ERR_HDR;
            // WRACK is a single beat; RDATA header must be followed by data
            end else if (last_i == exp_rd_i) begin
               err_o  = 1'b1;
               code_o = ERR_FRAME;
            end else begin
               end_o = !exp_rd_i;
            end
         end else begin
            cnt_d = cnt_q + 8'd1;
            if (last_i != (cnt_q == exp_len_i)) begin
               err_o  = 1'b1;
               code_o = ERR_FRAME;
            end else begin
               end_o = last_i;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/m_reqgen.sv
// m_reqgen: issues alternating WRITE/READ requests and checks the responses.
// Ports: start/num_reqs/base_addr/len config; O_* requests; I_* responses; busy/done/error/err_code/req_count.
module m_reqgen
   import m_reqgen_pkg::*;
#(
   parameter logic [7:0]  SRC_ID  = 8'h01,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] num_reqs,
   input  logic [28:0] base_addr,
   input  logic [7:0]  len,
   output logic        O_TVALID,
   input  logic        O_TREADY,
   output logic [63:0] O_TDATA,
   output logic        O_TLAST,
   input  logic        I_TVALID,
   output logic        I_TREADY,
   input  logic [63:0] I_TDATA,
   input  logic        I_TLAST,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [1:0]  err_code,
   output logic [15:0] req_count
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   state_e        state_q, state_d;
   logic [15:0]   k_q, k_d, num_q, num_d, cnt_q, cnt_d;
   logic [28:0]   base_q, base_d;
   logic [7:0]    len_q, len_d, beat_q, beat_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          ov_q, ov_d, ol_q, ol_d, ir_q, ir_d;
   logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic [63:0]   od_q, od_d;
   logic [1:0]    code_q, code_d;

   logic          o_acc, i_acc, chk_beat, chk_err, chk_end;
   logic [1:0]    chk_code;
   logic [15:0]   k_nxt;
   logic [28:0]   cur_addr, nxt_addr;

   assign k_nxt    = k_q + 16'd1;
   assign cur_addr = base_q + 29'(k_q);
   assign nxt_addr = base_q + 29'(k_nxt);
   assign o_acc    = ov_q && O_TREADY;
   assign i_acc    = ir_q && I_TVALID;
   assign chk_beat = i_acc
                  && (state_q == S_RESP_HDR || state_q == S_RESP_DATA);

   m_resp_check #(.SRC_ID(SRC_ID)) u_chk (
      .clk        (clk),
      .reset      (reset),
      .beat_i     (chk_beat),
      .hdr_i      (state_q == S_RESP_HDR),
      .exp_rd_i   (k_q[0]),
      .exp_addr_i (cur_addr),
      .exp_len_i  (len_q),
      .data_i     (I_TDATA),
      .last_i     (I_TLAST),
      .err_o      (chk_err),
      .code_o     (chk_code),
      .end_o      (chk_end)
   );

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      num_d   = num_q;
      cnt_d   = cnt_q;
      base_d  = base_q;
      len_d   = len_q;
      beat_d  = beat_q;
      tmo_d   = tmo_q;
      ov_d    = ov_q;
      ol_d    = ol_q;
      od_d    = od_q;
      ir_d    = ir_q;
      busy_d  = busy_q;
      done_d  = done_q;
      err_d   = err_q;
      code_d  = code_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               num_d  = num_reqs;
               base_d = base_addr;
               len_d  = len;
               k_d    = '0;
               cnt_d  = '0;
               busy_d = 1'b1;
               done_d = 1'b0;
               err_d  = 1'b0;
               code_d = ERR_NONE;
               if (num_reqs == 16'd0) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_REQ_HDR;
                  ov_d    = 1'b1;
                  od_d    = mk_hdr(SRC_ID, len, PT_WRITE, base_addr);
                  ol_d    = 1'b0;
               end
            end
         end
         S_REQ_HDR, S_REQ_DATA: begin
            if (o_acc) begin
               if (ol_q) begin
                  state_d = S_RESP_HDR;
                  ov_d    = 1'b0;
                  ol_d    = 1'b0;
                  ir_d    = 1'b1;
                  tmo_d   = '0;
               end else begin
                  // beat_q counts data beats already sent after the header
                  state_d = S_REQ_DATA;
                  beat_d  = (state_q == S_REQ_HDR) ? 8'd0 : beat_q + 8'd1;
                  od_d    = mk_data(k_q, beat_d);
                  ol_d    = (beat_d == len_q);
               end
            end
         end
         S_RESP_HDR, S_RESP_DATA: begin
            if (i_acc) begin
               tmo_d = '0;
               if (chk_err) begin
                  err_d   = 1'b1;
                  code_d  = chk_code;
                  state_d = I_TLAST ? S_DONE : S_DRAIN;
                  ir_d    = !I_TLAST;
               end else if (chk_end) begin
                  cnt_d = cnt_q + 16'd1;
                  ir_d  = 1'b0;
                  if (k_nxt == num_q) begin
                     state_d = S_DONE;
                  end else begin
                     k_d     = k_nxt;
                     state_d = S_REQ_HDR;
                     ov_d    = 1'b1;
                     od_d    = mk_hdr(SRC_ID, len_q,
                                      k_q[0] ? PT_WRITE : PT_READ,
                                      nxt_addr);
                     ol_d    = !k_q[0];
                  end
               end else begin
                  state_d = S_RESP_DATA;
               end
            end else if (tmo_q == TMO_LAST) begin
               err_d   = 1'b1;
               code_d  = ERR_TMO;
               state_d = S_DONE;
               ir_d    = 1'b0;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         S_DRAIN: begin
            if (i_acc) begin
               tmo_d = '0;
               if (I_TLAST) begin
                  state_d = S_DONE;
                  ir_d    = 1'b0;
               end
            end else if (tmo_q == TMO_LAST) begin
               state_d = S_DONE;
               ir_d    = 1'b0;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         S_DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         num_q   <= '0;
         cnt_q   <= '0;
         base_q  <= '0;
         len_q   <= '0;
         beat_q  <= '0;
         tmo_q   <= '0;
         ov_q    <= 1'b0;
         ol_q    <= 1'b0;
         od_q    <= '0;
         ir_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         code_q  <= ERR_NONE;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         num_q   <= num_d;
         cnt_q   <= cnt_d;
         base_q  <= base_d;
         len_q   <= len_d;
         beat_q  <= beat_d;
         tmo_q   <= tmo_d;
         ov_q    <= ov_d;
         ol_q    <= ol_d;
         od_q    <= od_d;
         ir_q    <= ir_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         code_q  <= code_d;
      end
   end

   assign O_TVALID  = ov_q;
   assign O_TDATA   = od_q;
   assign O_TLAST   = ol_q;
   assign I_TREADY  = ir_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign error     = err_q;
   assign err_code  = code_q;
   assign req_count = cnt_q;

endmodule

// File: tb/tb_m_reqgen.sv
// tb_m_reqgen: randomized bench for m_reqgen with a packet-level model
// of the request stream and a scripted responder.
module tb_m_reqgen;

   localparam logic [7:0] SRC = 8'h01;
   localparam int TMO    = 64;
   localparam int BUDGET = 20000;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] num_reqs;
   logic [28:0] base_addr;
   logic [7:0]  len;
   logic        O_TVALID, O_TREADY, O_TLAST;
   logic [63:0] O_TDATA;
   logic        I_TVALID, I_TREADY, I_TLAST;
   logic [63:0] I_TDATA;
   logic        busy, done, error;
   logic [1:0]  err_code;
   logic [15:0] req_count;

   int    n_chk = 0;
   int    n_fail = 0;
   string cur = "init";

   always #5 clk = ~clk;

   m_reqgen #(.SRC_ID(SRC), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .start(start),
      .num_reqs(num_reqs), .base_addr(base_addr), .len(len),
      .O_TVALID(O_TVALID), .O_TREADY(O_TREADY),
      .O_TDATA(O_TDATA), .O_TLAST(O_TLAST),
      .I_TVALID(I_TVALID), .I_TREADY(I_TREADY),
      .I_TDATA(I_TDATA), .I_TLAST(I_TLAST),
      .busy(busy), .done(done), .error(error),
      .err_code(err_code), .req_count(req_count)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s/%s got=%h exp=%h", cur, tag, got, exp);
      end
   endtask

   // header built arithmetically from the field layout
   function automatic logic [63:0] mkh(input logic [7:0] s,
      input logic [7:0] src, input logic [7:0] l,
      input logic [1:0] t, input logic [28:0] a);
      return ({56'd0, s} << 56) | ({56'd0, src} << 48)
           | ({56'd0, l} << 40) | ({62'd0, t} << 32)
           | ({35'd0, a} << 3);
   endfunction

   task automatic check_rst();
      chk("rst_ov", 64'(O_TVALID), 64'd0);
      chk("rst_od", O_TDATA, 64'd0);
      chk("rst_ol", 64'(O_TLAST), 64'd0);
      chk("rst_ir", 64'(I_TREADY), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_err", 64'(error), 64'd0);
      chk("rst_code", 64'(err_code), 64'd0);
      chk("rst_cnt", 64'(req_count), 64'd0);
   endtask

   // mode: 0 normal, 1 bad srcid, 2 short RDATA, 3 no response
   task automatic run(input string nm, input int nreq,
      input logic [28:0] base, input logic [7:0] ln, input int thr,
      input int mode, input int x_iss, input int x_cnt, input int x_code);
      logic [63:0] eq_d[$];
      logic        eq_l[$];
      logic [63:0] rq_d[$];
      logic        rq_l[$];
      logic [63:0] pd;
      logic        stall, pl, i_acc, err_seen;
      logic [28:0] a;
      int          iss, tl_cyc, nb;
      cur = nm;
      for (int k = 0; k < nreq; k++) begin
         a = base + 29'(k);
         if (k % 2 == 0) begin
            eq_d.push_back(mkh(8'hff, SRC, ln, 2'b01, a));
            eq_l.push_back(1'b0);
            for (int i = 0; i <= int'(ln); i++) begin
               eq_d.push_back(64'hda7a_0000_0000_0000
                              + 64'(k) * 256 + 64'(i));
               eq_l.push_back(i == int'(ln));
            end
         end else begin
            eq_d.push_back(mkh(8'h00, SRC, ln, 2'b00, a));
            eq_l.push_back(1'b1);
         end
      end
      stall = 0; pl = 0; pd = '0; i_acc = 0; err_seen = 0;
      iss = 0; tl_cyc = 0;
      @(negedge clk);
      num_reqs = nreq[15:0]; base_addr = base; len = ln; start = 1;
      for (int cyc = 0; cyc < BUDGET; cyc++) begin
         @(negedge clk);
         if (cyc == 0) begin
            chk("st_vld", 64'(O_TVALID), 64'(nreq != 0));
            chk("st_busy", 64'(busy), 64'd1);
            chk("st_done", 64'(done), 64'd0);
            chk("st_err", 64'(error), 64'd0);
         end
         if (done) break;
         start = busy && ($urandom_range(0, 19) == 0);
         if (stall) begin
            chk("hold_v", 64'(O_TVALID), 64'd1);
            chk("hold_d", O_TDATA, pd);
            chk("hold_l", 64'(O_TLAST), 64'(pl));
         end
         O_TREADY = (thr == 0) || ($urandom_range(0, 99) >= thr);
         stall = O_TVALID && !O_TREADY;
         pd = O_TDATA; pl = O_TLAST;
         if (O_TVALID && O_TREADY) begin
            if (eq_d.size() == 0) begin
               chk("req_extra", 64'(O_TVALID), 64'd0);
            end else begin
               chk("req_d", O_TDATA, eq_d[0]);
               chk("req_l", 64'(O_TLAST), 64'(eq_l[0]));
               if (eq_l[0]) begin
                  tl_cyc = cyc;
                  a = base + 29'(iss);
                  if (mode != 3 && iss % 2 == 0) begin
                     rq_d.push_back(mkh(8'h00, mode == 1 ? 8'h05 : SRC,
                                        ln, 2'b11, a));
                     rq_l.push_back(1'b1);
                  end else if (mode != 3) begin
                     rq_d.push_back(mkh(8'h00, mode == 1 ? 8'h05 : SRC,
                                        ln, 2'b10, a));
                     rq_l.push_back(1'b0);
                     nb = (mode == 2) ? int'(ln) : int'(ln) + 1;
                     for (int i = 1; i <= nb; i++) begin
                        rq_d.push_back({$urandom, $urandom});
                        rq_l.push_back(i == nb);
                     end
                  end
                  iss++;
               end
               void'(eq_d.pop_front());
               void'(eq_l.pop_front());
            end
         end
         if (i_acc) I_TVALID = 0;
         if (!I_TVALID && rq_d.size() > 0
             && (thr == 0 || $urandom_range(0, 99) >= thr)) begin
            I_TVALID = 1;
            I_TDATA  = rq_d.pop_front();
            I_TLAST  = rq_l.pop_front();
         end
         i_acc = I_TVALID && I_TREADY;
         // error registers on the TMO-th edge after the TLAST edge
         if (mode == 3 && !err_seen && error) begin
            err_seen = 1;
            chk("tmo_lat", 64'(cyc - tl_cyc), 64'(TMO + 1));
         end
      end
      start = 0; O_TREADY = 0; I_TVALID = 0; I_TLAST = 0;
      chk("end_done", 64'(done), 64'd1);
      chk("end_busy", 64'(busy), 64'd0);
      chk("end_err", 64'(error), 64'(x_code != 0));
      chk("end_code", 64'(err_code), 64'(x_code));
      chk("end_cnt", 64'(req_count), 64'(x_cnt));
      chk("end_iss", 64'(iss), 64'(x_iss));
      chk("end_ov", 64'(O_TVALID), 64'd0);
      chk("end_ir", 64'(I_TREADY), 64'd0);
   endtask

   initial begin
      logic hit;
      logic [7:0] rl;
      reset = 0; start = 0; num_reqs = '0; base_addr = '0; len = '0;
      O_TREADY = 0; I_TVALID = 0; I_TDATA = '0; I_TLAST = 0;
      repeat (3) @(negedge clk);
      check_rst();
      reset = 1;

      run("basic", 2, 29'h100, 8'd3, 0, 0, 2, 2, 0);
      run("wrap", 16, 29'h1fff_fffa, 8'd2, 40, 0, 16, 16, 0);
      rl = 8'($urandom_range(0, 6));
      run("rand", 16, 29'($urandom), rl, 50, 0, 16, 16, 0);
      run("len0", 5, 29'($urandom), 8'd0, 30, 0, 5, 5, 0);
      run("zero", 0, 29'h10, 8'd1, 0, 0, 0, 0, 0);
      run("badsrc", 2, 29'h40, 8'd2, 0, 1, 1, 0, 1);
      run("short", 2, 29'h200, 8'd3, 0, 2, 2, 1, 2);
      run("tmo", 1, 29'h300, 8'd1, 0, 3, 1, 0, 3);

      cur = "rst_mid";
      @(negedge clk);
      num_reqs = 16'd4; base_addr = 29'h80; len = 8'd3;
      start = 1; O_TREADY = 1;
      @(negedge clk);
      start = 0;
      hit = 0;
      for (int c = 0; c < 50 && !hit; c++) begin
         if (O_TVALID && O_TDATA[63:48] == 16'hda7a
             && O_TDATA[7:0] == 8'd1) hit = 1;
         else @(negedge clk);
      end
      chk("rst_hit", 64'(hit), 64'd1);
      reset = 0;
      @(negedge clk);
      check_rst();
      reset = 1; O_TREADY = 0;

      run("post_rst", 3, 29'h500, 8'd1, 20, 0, 3, 3, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
